// File: rtl/secure_key_vault_if.sv
// -----------------------------------------------------------------------------
// secure_key_vault_if
// Request/response bus between the request agent and the key vault.
//
// Signals:
//   req_valid   agent -> vault   request present
//   req_ready   vault -> agent   vault accepts a request this cycle
//   req_op      agent -> vault   0=WRITE 1=READ 2=LOCK 3=ZEROIZE
//   req_slot    agent -> vault   target slot (one extra bit so that
//                                out-of-range indices can be expressed)
//   req_data    agent -> vault   key for WRITE
//   req_export  agent -> vault   WRITE only: slot may be read back
//   rsp_valid   vault -> agent   one-cycle response pulse
//   rsp_status  vault -> agent   0=OK 1=LOCKED 2=DENIED 3=BAD_SLOT
//   rsp_data    vault -> agent   READ result, zero unless an OK READ
//
// Modports: master = request agent, slave = vault.
// -----------------------------------------------------------------------------
interface secure_key_vault_if #(
  parameter int KEY_W     = 128,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [SLOT_W:0]   req_slot;
  logic [KEY_W-1:0]  req_data;
  logic              req_export;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [KEY_W-1:0]  rsp_data;

  modport master (
    output req_valid,
    output req_op,
    output req_slot,
    output req_data,
    output req_export,
    input  req_ready,
    input  rsp_valid,
    input  rsp_status,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_slot,
    input  req_data,
    input  req_export,
    output req_ready,
    output rsp_valid,
    output rsp_status,
    output rsp_data
  );

endinterface

// File: rtl/secure_key_vault.sv
// -----------------------------------------------------------------------------
// secure_key_vault
// Multi-slot key store for the crypto subsystem. Each slot holds a KEY_W-bit
// key plus valid, lock and export flags. A request agent writes, reads, locks
// and zeroizes slots over the request bus; a separate engine port delivers the
// selected key to the cipher core without exposing it on the request bus.
// No key is built in: reset clears every slot to zero.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   bus            slave modport of secure_key_vault_if (request/response)
//   eng_slot       in   slot selected by the cipher engine
//   eng_key        out  registered key for the engine (zero when not valid)
//   eng_key_valid  out  eng_key holds a populated slot's key
//   busy           out  zeroize sweep in progress
//
// Timing:
//   - Normal requests respond one cycle after acceptance.
//   - ZEROIZE clears one slot per cycle for NUM_SLOTS cycles and responds on
//     the cycle after the last slot clears (NUM_SLOTS+1 cycles after accept).
//   - Engine port has one cycle of latency and samples pre-write storage.
// -----------------------------------------------------------------------------
module secure_key_vault #(
  parameter int KEY_W     = 128,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  secure_key_vault_if.slave     bus,
  input  logic [SLOT_W-1:0]     eng_slot,
  output logic [KEY_W-1:0]      eng_key,
  output logic                  eng_key_valid,
  output logic                  busy
);

  // Request opcodes
  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_LOCK    = 2'd2;
  localparam logic [1:0] OP_ZEROIZE = 2'd3;

  // Response status codes
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_DENIED   = 2'd2;
  localparam logic [1:0] ST_BAD_SLOT = 2'd3;

  localparam logic [SLOT_W:0]   LP_NUM_SLOTS = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LP_LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ZERO = 1'b1
  } state_t;

  // Control state
  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic [SLOT_W-1:0]  r_zidx;

  // Key storage and per-slot flags
  logic [KEY_W-1:0]     r_key [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_valid;
  logic [NUM_SLOTS-1:0] r_lock;
  logic [NUM_SLOTS-1:0] r_export;

  // Registered outputs
  logic               r_rsp_valid;
  logic [1:0]         r_rsp_status;
  logic [KEY_W-1:0]   r_rsp_data;
  logic [KEY_W-1:0]   r_eng_key;
  logic               r_eng_key_valid;

  // Decoded request
  logic               w_accept;
  logic               w_slot_ok;
  logic [SLOT_W-1:0]  w_idx;
  logic               w_zero_start;
  logic               w_eng_in_range;
  logic               w_eng_hit;

  assign w_accept     = (r_state == S_IDLE) && r_ready && bus.req_valid;
  assign w_slot_ok    = (bus.req_slot < LP_NUM_SLOTS);
  assign w_idx        = bus.req_slot[SLOT_W-1:0];
  assign w_zero_start = w_accept && (bus.req_op == OP_ZEROIZE);

  // The engine is starved both during the sweep and on the very cycle the
  // sweep is accepted, so no key leaves on the engine port while busy=1.
  assign w_eng_in_range = ({1'b0, eng_slot} < LP_NUM_SLOTS);
  assign w_eng_hit      = w_eng_in_range && r_valid[eng_slot] &&
                          !r_busy && !w_zero_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ready         <= 1'b0;
      r_busy          <= 1'b0;
      r_zidx          <= '0;
      r_valid         <= '0;
      r_lock          <= '0;
      r_export        <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_status    <= ST_OK;
      r_rsp_data      <= '0;
      r_eng_key       <= '0;
      r_eng_key_valid <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_key[i] <= '0;
      end
    end else begin
      // Response fields idle at zero; only a cycle carrying a response
      // overrides them below.
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
      r_rsp_data   <= '0;

      // Engine port reads storage before this cycle's write lands.
      r_eng_key_valid <= w_eng_hit;
      r_eng_key       <= w_eng_hit ? r_key[eng_slot] : '0;

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_rsp_valid <= 1'b1;
            if (bus.req_op == OP_ZEROIZE) begin
              // Response deferred to the end of the sweep.
              r_rsp_valid <= 1'b0;
              r_state     <= S_ZERO;
              r_busy      <= 1'b1;
              r_ready     <= 1'b0;
              r_zidx      <= '0;
            end else if (!w_slot_ok) begin
              r_rsp_status <= ST_BAD_SLOT;
            end else begin
              case (bus.req_op)
                OP_WRITE: begin
                  if (r_lock[w_idx]) begin
                    r_rsp_status <= ST_LOCKED;
                  end else begin
                    r_key[w_idx]    <= bus.req_data;
                    r_valid[w_idx]  <= 1'b1;
                    r_export[w_idx] <= bus.req_export;
                    r_rsp_status    <= ST_OK;
                  end
                end
                OP_READ: begin
                  // Lock does not gate readability; only valid+export do.
                  if (r_valid[w_idx] && r_export[w_idx]) begin
                    r_rsp_status <= ST_OK;
                    r_rsp_data   <= r_key[w_idx];
                  end else begin
                    r_rsp_status <= ST_DENIED;
                  end
                end
                OP_LOCK: begin
                  if (r_valid[w_idx]) begin
                    r_lock[w_idx] <= 1'b1;
                    r_rsp_status  <= ST_OK;
                  end else begin
                    r_rsp_status <= ST_DENIED;
                  end
                end
                default: begin
                  r_rsp_status <= ST_OK;
                end
              endcase
            end
          end
        end

        S_ZERO: begin
          r_key[r_zidx]    <= '0;
          r_valid[r_zidx]  <= 1'b0;
          r_lock[r_zidx]   <= 1'b0;
          r_export[r_zidx] <= 1'b0;
          if (r_zidx == LP_LAST_SLOT) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= ST_OK;
          end else begin
            r_zidx <= r_zidx + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_rsp_status;
  assign bus.rsp_data   = r_rsp_data;
  assign eng_key        = r_eng_key;
  assign eng_key_valid  = r_eng_key_valid;
  assign busy           = r_busy;

endmodule
